// File: rtl/dcm_rst_ctrl_pkg.sv
// dcm_rst_ctrl_pkg: state encoding and widths shared by the DCM reset supervisor.
package dcm_rst_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_DCM_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;
  localparam int RELOCK_W = 8;
endpackage

// File: rtl/dcm_rst_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/dcm_rst_ctrl.sv
// dcm_rst_ctrl: pulses DCM RST, waits for stable lock, then releases the system reset.
module dcm_rst_ctrl
  import dcm_rst_ctrl_pkg::*;
#(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked_in,
  output logic                dcm_rst,
  output logic                sys_rst,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_cnt
);
  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_locked_s;
  logic                r_dcm_rst;
  logic                r_sys_rst;
  logic                r_ready;
  logic [RELOCK_W-1:0] r_relock;
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (locked_in),
    .o_q   (w_locked_s)
  );
  // Lock status is checked before the counter so drop/arrival win over expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_DCM_RST:   w_next = (r_cnt == CNT_W'(DCM_RST_CYCLES - 1)) ? ST_WAIT_LOCK : ST_DCM_RST;
      ST_WAIT_LOCK: w_next = w_locked_s ? ST_SETTLE :
                             (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) ? ST_DCM_RST : ST_WAIT_LOCK;
      ST_SETTLE:    w_next = !w_locked_s ? ST_WAIT_LOCK :
                             (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) ? ST_RUN : ST_SETTLE;
      default:      w_next = w_locked_s ? ST_RUN : ST_WAIT_LOCK;
    endcase
  end
  // Outputs are registered from the next state so they change with the state flops.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= ST_DCM_RST;
      r_cnt     <= '0;
      r_dcm_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_relock  <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_dcm_rst <= (w_next == ST_DCM_RST);
      r_sys_rst <= (w_next != ST_RUN);
      r_ready   <= (w_next == ST_RUN);
      if (r_state == ST_RUN && w_next == ST_WAIT_LOCK && r_relock != '1)
        r_relock <= r_relock + 1'b1;
    end
  assign dcm_rst    = r_dcm_rst;
  assign sys_rst    = r_sys_rst;
  assign ready      = r_ready;
  assign relock_cnt = r_relock;
endmodule

// File: tb/tb_dcm_rst_ctrl.sv
// tb_dcm_rst_ctrl: directed scenarios checked against a phase/deadline model of the supervisor.
module tb_dcm_rst_ctrl;
  localparam int DRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked_in;
  logic       dcm_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] relock_cnt;
  int checks = 0;
  int errors = 0;
  dcm_rst_ctrl #(
    .DCM_RST_CYCLES (DRC),
    .LOCK_TIMEOUT   (LTO),
    .SETTLE_CYCLES  (STC),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked_in  (locked_in),
    .dcm_rst    (dcm_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .relock_cnt (relock_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: phase 0=dcm reset, 1=wait lock, 2=settle, 3=run; a phase ends when
  // its age (edges spent in it, counting the current one) reaches its length.
  // Lock seen at an edge is the locked_in sampled two edges earlier.
  int   m_n, m_t0, m_ph, m_rc, m_age;
  logic m_h1, m_h2;
  assign m_age = m_n - m_t0 + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_n <= 0; m_t0 <= 0; m_ph <= 0; m_rc <= 0; m_h1 <= 1'b0; m_h2 <= 1'b0;
    end else begin
      m_n  <= m_n + 1;
      m_h1 <= locked_in;
      m_h2 <= m_h1;
      case (m_ph)
        0: if (m_age == DRC) begin m_ph <= 1; m_t0 <= m_n + 1; end
        1: if (m_h2) begin m_ph <= 2; m_t0 <= m_n + 1; end
           else if (m_age == LTO) begin m_ph <= 0; m_t0 <= m_n + 1; end
        2: if (!m_h2) begin m_ph <= 1; m_t0 <= m_n + 1; end
           else if (m_age == STC) begin m_ph <= 3; m_t0 <= m_n + 1; end
        default: if (!m_h2) begin
          m_ph <= 1; m_t0 <= m_n + 1; m_rc <= (m_rc < 255) ? m_rc + 1 : 255;
        end
      endcase
    end
  always @(negedge clk) begin
    chk("model_dcm_rst", dcm_rst, int'(m_ph == 0));
    chk("model_sys_rst", sys_rst, int'(m_ph != 3));
    chk("model_ready", ready, int'(m_ph == 3));
    chk("model_relock_cnt", relock_cnt, m_rc);
  end
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_dcm_rst"}, dcm_rst, 1);
    chk({nm, "_sys_rst"}, sys_rst, 1);
    chk({nm, "_ready"}, ready, 0);
    chk({nm, "_relock"}, relock_cnt, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    locked_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    // Power-up: edge 0 is the first posedge after release.
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pu_dcm_rst_e2", dcm_rst, 1);
    @(negedge clk);
    chk("pu_dcm_rst_e3", dcm_rst, 0);
    repeat (6) @(negedge clk);
    locked_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("pu_sys_rst_e19", sys_rst, 1);
    @(negedge clk);
    chk("pu_sys_rst_e20", sys_rst, 0);
    chk("pu_ready_e20", ready, 1);
    chk("pu_relock_e20", relock_cnt, 0);
    // Three one-cycle lock losses in run.
    for (int i = 0; i < 3; i++) begin
      locked_in = 1'b0;
      @(negedge clk);
      locked_in = 1'b1;
      @(negedge clk);
      chk("loss_sys_rst_e1", sys_rst, 0);
      @(negedge clk);
      chk("loss_sys_rst_e2", sys_rst, 1);
      repeat (10) @(negedge clk);
    end
    chk("loss_relock3", relock_cnt, 3);
    chk("loss_ready", ready, 1);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_run");
    @(negedge clk);
    // Settle glitch: lock already synchronized, settle starts after edge 4.
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    locked_in = 1'b0;
    @(negedge clk);
    locked_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_ready_e12", ready, 0);
    chk("glitch_relock_e12", relock_cnt, 0);
    repeat (7) @(negedge clk);
    chk("glitch_ready_e19", ready, 0);
    @(negedge clk);
    chk("glitch_ready_e20", ready, 1);
    chk("glitch_relock_e20", relock_cnt, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("settle_dcm_rst", dcm_rst, 0);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_settle");
    locked_in = 1'b0;
    @(negedge clk);
    // Timeout: dcm_rst re-pulses every 24 cycles.
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_dcm_rst_e3", dcm_rst, 0);
    repeat (19) @(negedge clk);
    chk("to_dcm_rst_e22", dcm_rst, 0);
    @(negedge clk);
    chk("to_dcm_rst_e23", dcm_rst, 1);
    repeat (3) @(negedge clk);
    chk("to_dcm_rst_e26", dcm_rst, 1);
    @(negedge clk);
    chk("to_dcm_rst_e27", dcm_rst, 0);
    repeat (20) @(negedge clk);
    chk("to_dcm_rst_e47", dcm_rst, 1);
    chk("to_sys_rst_e47", sys_rst, 1);
    // Saturation: 260 losses in run.
    locked_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("sat_ready_start", ready, 1);
    for (int i = 0; i < 260; i++) begin
      locked_in = 1'b0;
      @(negedge clk);
      locked_in = 1'b1;
      repeat (12) @(negedge clk);
    end
    chk("sat_relock", relock_cnt, 255);
    chk("sat_ready_end", ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
